// File: rtl/adc_ring_ram.sv
// CPU data RAM with per-channel ADC capture rings fed through a round-robin arbiter.
// CPU read latency 1 cycle; one ring write per cycle, and a sample that arrives at a still-full holding register is dropped and counted.
module adc_ring_ram #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int DEPTH         = 4096,
   parameter int NUM_CH        = 4,
   parameter int RING_LOG2     = 8,
   parameter int ADC_BASE      = 3072,
   parameter int ADC_WIDTH     = 12
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wEn,
   input  logic [ADDRESS_WIDTH-1:0]       addr,
   input  logic [DATA_WIDTH-1:0]          dataIn,
   output logic [DATA_WIDTH-1:0]          dataOut,
   input  logic [NUM_CH-1:0]              adc_valid,
   input  logic [NUM_CH*ADC_WIDTH-1:0]    adc_data,
   input  logic [NUM_CH-1:0]              ch_clr,
   output logic [NUM_CH*RING_LOG2-1:0]    wr_ptr,
   output logic [NUM_CH-1:0]              wrapped,
   output logic [NUM_CH*8-1:0]            drop_cnt
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [DATA_WIDTH-1:0]    mem [DEPTH];

   logic [DATA_WIDTH-1:0]    dout_q, dout_d;
   logic [ADC_WIDTH-1:0]     hold_q [NUM_CH];
   logic [ADC_WIDTH-1:0]     hold_d [NUM_CH];
   logic [NUM_CH-1:0]        hold_full_q, hold_full_d;
   logic [RING_LOG2-1:0]     ptr_q [NUM_CH];
   logic [RING_LOG2-1:0]     ptr_d [NUM_CH];
   logic [NUM_CH-1:0]        wrapped_q, wrapped_d;
   logic [7:0]               drop_q [NUM_CH];
   logic [7:0]               drop_d [NUM_CH];
   logic [CH_W-1:0]          rr_q, rr_d;

   logic                     gnt_vld;
   logic                     gnt_eff;
   logic [CH_W-1:0]          gnt_idx;
   logic [CH_W:0]            cand;
   logic [ADDRESS_WIDTH-1:0] adc_addr;
   logic [DATA_WIDTH-1:0]    adc_wdat;

   // First full holding register at or after rr_q, wrapping around.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, rr_q} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
         if (!gnt_vld && hold_full_q[cand[CH_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[CH_W-1:0];
         end
      end
   end

   // A grant to a channel being cleared is swallowed and does not rotate priority.
   always_comb begin
      gnt_eff  = gnt_vld && !ch_clr[gnt_idx];
      adc_addr = ADDRESS_WIDTH'(ADC_BASE)
               + (ADDRESS_WIDTH'(gnt_idx) << RING_LOG2)
               + ADDRESS_WIDTH'(ptr_q[gnt_idx]);
      adc_wdat = DATA_WIDTH'(hold_q[gnt_idx]);
      rr_d     = rr_q;
      if (gnt_eff) rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      dout_d   = mem[addr];
   end

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      ptr_d       = ptr_q;
      wrapped_d   = wrapped_q;
      drop_d      = drop_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_clr[c]) begin
            hold_full_d[c] = 1'b0;
            ptr_d[c]       = '0;
            wrapped_d[c]   = 1'b0;
            drop_d[c]      = '0;
         end else begin
            if (gnt_eff && gnt_idx == CH_W'(c)) begin
               ptr_d[c]       = ptr_q[c] + 1'b1;
               hold_full_d[c] = 1'b0;
               if (&ptr_q[c]) wrapped_d[c] = 1'b1;
            end
            if (adc_valid[c]) begin
               if (hold_full_q[c] && !(gnt_eff && gnt_idx == CH_W'(c))) begin
                  if (drop_q[c] != 8'hFF) drop_d[c] = drop_q[c] + 8'd1;
               end else begin
                  hold_d[c]      = adc_data[c*ADC_WIDTH +: ADC_WIDTH];
                  hold_full_d[c] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_q      <= '0;
         hold_full_q <= '0;
         wrapped_q   <= '0;
         rr_q        <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            hold_q[c] <= '0;
            ptr_q[c]  <= '0;
            drop_q[c] <= '0;
         end
      end else begin
         dout_q      <= dout_d;
         hold_full_q <= hold_full_d;
         wrapped_q   <= wrapped_d;
         rr_q        <= rr_d;
         hold_q      <= hold_d;
         ptr_q       <= ptr_d;
         drop_q      <= drop_d;
      end
   end

   // ADC write is issued last so it overrides a CPU write to the same word.
   always_ff @(posedge clk) begin
      if (wEn)     mem[addr]     <= dataIn;
      if (gnt_eff) mem[adc_addr] <= adc_wdat;
   end

   always_comb begin
      dataOut  = dout_q;
      wrapped  = wrapped_q;
      wr_ptr   = '0;
      drop_cnt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wr_ptr[c*RING_LOG2 +: RING_LOG2] = ptr_q[c];
         drop_cnt[c*8 +: 8]               = drop_q[c];
      end
   end

endmodule

// File: tb/tb_adc_ring_ram.sv
// Directed bench for adc_ring_ram: CPU port, single/multi-channel capture, contention, wrap, clear, collision.
module tb_adc_ring_ram;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NC = 4;
   localparam int RL = 8;
   localparam int XW = 12;

   logic             clk = 1'b0;
   logic             reset;
   logic             wEn;
   logic [AW-1:0]    addr;
   logic [DW-1:0]    dataIn;
   logic [DW-1:0]    dataOut;
   logic [NC-1:0]    adc_valid;
   logic [NC*XW-1:0] adc_data;
   logic [NC-1:0]    ch_clr;
   logic [NC*RL-1:0] wr_ptr;
   logic [NC-1:0]    wrapped;
   logic [NC*8-1:0]  drop_cnt;

   int vecs = 0;
   int errs = 0;

   adc_ring_ram #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(4096), .NUM_CH(NC),
      .RING_LOG2(RL), .ADC_BASE(3072), .ADC_WIDTH(XW)
   ) dut (
      .clk(clk), .reset(reset), .wEn(wEn), .addr(addr), .dataIn(dataIn),
      .dataOut(dataOut), .adc_valid(adc_valid), .adc_data(adc_data),
      .ch_clr(ch_clr), .wr_ptr(wr_ptr), .wrapped(wrapped), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int a, input logic [31:0] exp, input string tag);
      wEn  = 1'b0;
      addr = AW'(a);
      tick(1);
      chk(tag, dataOut, exp);
   endtask

   task automatic set_ch(input int c, input logic [XW-1:0] v);
      adc_data[c*XW +: XW] = v;
   endtask

   function automatic logic [31:0] ptr(input int c);
      return 32'(wr_ptr[c*RL +: RL]);
   endfunction

   function automatic logic [31:0] drp(input int c);
      return 32'(drop_cnt[c*8 +: 8]);
   endfunction

   initial begin
      reset = 1'b1; wEn = 1'b0; addr = '0; dataIn = '0;
      adc_valid = '0; adc_data = '0; ch_clr = '0;
      tick(2);
      chk("rst_dout",    dataOut,  32'h0);
      chk("rst_wr_ptr",  wr_ptr,   32'h0);
      chk("rst_wrapped", 32'(wrapped), 32'h0);
      chk("rst_drop",    drop_cnt, 32'h0);
      reset = 1'b0;
      tick(1);

      // CPU port: read-before-write, then 1-cycle read latency
      wEn = 1'b1; addr = 12'd5; dataIn = 32'h0;
      tick(1);
      dataIn = 32'hDEADBEEF;
      tick(1);
      chk("cpu_rbw_old", dataOut, 32'h0);
      wEn = 1'b0;
      tick(1);
      chk("cpu_read", dataOut, 32'hDEADBEEF);

      // single sample on ch1
      adc_valid = 4'b0010; set_ch(1, 12'hABC);
      tick(1);
      adc_valid = '0;
      chk("ch1_ptr_capture", wr_ptr, 32'h0);
      tick(1);
      chk("ch1_ptr_written", wr_ptr, 32'h0000_0100);
      rd(3328, 32'h0000_0ABC, "ch1_mem");

      // reset mid-run: priority back to ch0, memory kept
      reset = 1'b1; tick(1); reset = 1'b0;
      chk("rst2_ptr", wr_ptr, 32'h0);
      rd(3328, 32'h0000_0ABC, "mem_survives_reset");

      // all four channels at once drain ch0..ch3 on consecutive edges
      adc_valid = 4'b1111;
      set_ch(0, 12'h1); set_ch(1, 12'h2); set_ch(2, 12'h3); set_ch(3, 12'h4);
      tick(1);
      adc_valid = '0;
      tick(1); chk("all_e1", wr_ptr, 32'h0000_0001);
      tick(1); chk("all_e2", wr_ptr, 32'h0000_0101);
      tick(1); chk("all_e3", wr_ptr, 32'h0001_0101);
      tick(1); chk("all_e4", wr_ptr, 32'h0101_0101);
      chk("all_drop", drop_cnt, 32'h0);
      rd(3072, 32'h1, "all_mem0");
      rd(3328, 32'h2, "all_mem1");
      rd(3584, 32'h3, "all_mem2");
      rd(3840, 32'h4, "all_mem3");

      // ch0 and ch2 streaming for 20 edges; ch0 data 0x100+k, ch2 0x200+k.
      // Grants alternate from ch0: ch0 gets 11 writes / 9 drops, ch2 10 / 10.
      adc_valid = 4'b0101;
      for (int k = 0; k < 20; k++) begin
         set_ch(0, 12'(12'h100 + k));
         set_ch(2, 12'(12'h200 + k));
         tick(1);
      end
      adc_valid = '0;
      tick(2);
      chk("str_ptr0",  ptr(0), 32'd12);
      chk("str_ptr2",  ptr(2), 32'd11);
      chk("str_drop0", drp(0), 32'd9);
      chk("str_drop2", drp(2), 32'd10);
      tick(1);
      chk("str_drained", wr_ptr, 32'h010B_010C);
      rd(3074, 32'h101, "str_ch0_off2");
      rd(3083, 32'h113, "str_ch0_off11");
      rd(3594, 32'h212, "str_ch2_off10");

      // ch3 wrap: clear first, then 257 isolated samples with data = index
      ch_clr = 4'b1000; tick(1); ch_clr = '0;
      chk("clr3_ptr", ptr(3), 32'd0);
      for (int i = 1; i <= 255; i++) begin
         adc_valid = 4'b1000; set_ch(3, 12'(i));
         tick(1);
         adc_valid = '0;
         tick(1);
      end
      chk("wrap_ptr255", ptr(3), 32'd255);
      chk("wrap_flag0",  32'(wrapped[3]), 32'd0);
      adc_valid = 4'b1000; set_ch(3, 12'd256); tick(1); adc_valid = '0; tick(1);
      chk("wrap_ptr0",   ptr(3), 32'd0);
      chk("wrap_flag1",  32'(wrapped[3]), 32'd1);
      adc_valid = 4'b1000; set_ch(3, 12'd257); tick(1); adc_valid = '0; tick(1);
      chk("wrap_ptr1",   ptr(3), 32'd1);
      rd(3840, 32'h101, "wrap_off0");
      rd(3841, 32'h002, "wrap_off1");

      // force a ch3 drop behind ch0, then clear ch3 while it holds a sample
      adc_valid = 4'b1001; set_ch(0, 12'h0CC); set_ch(3, 12'h0A1); tick(1);
      adc_valid = 4'b1000; set_ch(3, 12'h0A2); tick(1);
      chk("drop3_cnt", drp(3), 32'd1);
      adc_valid = '0; tick(1);
      chk("drop3_ptr", ptr(3), 32'd2);
      adc_valid = 4'b1000; set_ch(3, 12'h0A4); tick(1);
      ch_clr = 4'b1000; set_ch(3, 12'h0A5); tick(1);
      ch_clr = '0; adc_valid = '0;
      chk("clr_ptr",  ptr(3), 32'd0);
      chk("clr_wrap", 32'(wrapped[3]), 32'd0);
      chk("clr_drop", drp(3), 32'd0);
      tick(3);
      chk("clr_no_late_write", ptr(3), 32'd0);
      rd(3841, 32'h0A1, "clr_off1");
      rd(3842, 32'h003, "clr_off2_untouched");

      // CPU write and ADC grant hit 3072 on the same edge
      ch_clr = 4'b0001; tick(1); ch_clr = '0;
      adc_valid = 4'b0001; set_ch(0, 12'h5A5); tick(1);
      adc_valid = '0;
      wEn = 1'b1; addr = 12'd3072; dataIn = 32'hFFFF_FFFF; tick(1);
      wEn = 1'b0;
      chk("coll_ptr", ptr(0), 32'd1);
      rd(3072, 32'h0000_05A5, "coll_mem");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
